// File: rtl/video_fifo_pkg.sv
// Shared definitions for the video prefetch FIFO: sideband layout stored
// alongside every pixel in the RAM word.
package video_fifo_pkg;

  localparam int SB_W    = 2;
  localparam int SOF_BIT = 1;
  localparam int EOL_BIT = 0;

  // Sideband half of the RAM word; the top module appends the pixel data.
  typedef struct packed {
    logic sof;
    logic eol;
  } sb_t;

endpackage

// File: rtl/video_sdp_ram.sv
// Simple dual-port RAM with registered read, written so synthesis maps it
// onto block RAM (no reset on the array or the read register).
module video_sdp_ram #(
  parameter int WIDTH  = 26,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_prefetch_fifo.sv
// First-word-fall-through pixel FIFO: block RAM plus a 2-entry prefetch
// buffer, with fill level, almost flags, flush and sticky error flags.
module video_prefetch_fifo
  import video_fifo_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int DEPTH_W    = 8,
  parameter int AFULL_THR  = 2**DEPTH_W - 16,
  parameter int AEMPTY_THR = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              err_clr,
  input  logic              wr_en,
  output logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sof,
  input  logic              wr_eol,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_sof,
  output logic              rd_eol,
  output logic [DEPTH_W:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [DEPTH_W:0] CAPACITY = (DEPTH_W+1)'(1 << DEPTH_W);
  localparam logic [DEPTH_W:0] AF_LVL   = (DEPTH_W+1)'(AFULL_THR);
  localparam logic [DEPTH_W:0] AE_LVL   = (DEPTH_W+1)'(AEMPTY_THR);

  typedef struct packed {
    sb_t               sb;
    logic [DATA_W-1:0] data;
  } word_t;

  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_W:0]   ram_cnt, ram_cnt_nxt, level_q, level_nxt;
  logic               ram_q_vld, wr_vld_q, af_q, ae_q, ovf_q, udf_q;
  logic [1:0]         buf_cnt;
  logic [2:0]         occ_after;
  logic [SB_W-1:0]    sb_bits;
  word_t              wr_word, ram_q, buf0, buf1;
  logic               accept, consume, issue, head_vld, ovf_set, udf_set;

  always_comb begin
    sb_bits          = '0;
    sb_bits[SOF_BIT] = wr_sof;
    sb_bits[EOL_BIT] = wr_eol;
    wr_word.sb       = sb_t'(sb_bits);
    wr_word.data     = wr_data;

    head_vld = (buf_cnt != 2'd0);
    accept   = wr_en & wr_vld_q & ~flush;
    consume  = rd_en & head_vld & ~flush;
    ovf_set  = wr_en & ~wr_vld_q & ~flush;
    udf_set  = rd_en & ~head_vld & ~flush;

    // Only fetch when the word landing next cycle is guaranteed a free slot,
    // even if the consumer stalls in that cycle.
    occ_after = {1'b0, buf_cnt} + {2'b00, ram_q_vld} - {2'b00, consume};
    issue     = (ram_cnt != '0) && (occ_after <= 3'd1) && !flush;

    ram_cnt_nxt = ram_cnt + (DEPTH_W+1)'(accept) - (DEPTH_W+1)'(issue);
    level_nxt   = level_q + (DEPTH_W+1)'(accept) - (DEPTH_W+1)'(consume);
  end

  video_sdp_ram #(
    .WIDTH  (DATA_W + SB_W),
    .ADDR_W (DEPTH_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      ram_q_vld <= 1'b0;
      buf_cnt   <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      level_q   <= '0;
      wr_vld_q  <= !rst;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr + DEPTH_W'(accept);
      rd_ptr    <= rd_ptr + DEPTH_W'(issue);
      ram_cnt   <= ram_cnt_nxt;
      ram_q_vld <= issue;
      level_q   <= level_nxt;
      wr_vld_q  <= (level_nxt < CAPACITY);
      af_q      <= (level_nxt >= AF_LVL);
      ae_q      <= (level_nxt <= AE_LVL);
      // buf0 is always the head; buf1 only holds a word when buf_cnt == 2.
      unique case ({ram_q_vld, consume})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= ram_q;
          else                 buf1 <= ram_q;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= ram_q;
          end else begin
            buf0 <= buf1;
            buf1 <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Error flags survive flush; a new event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~err_clr);
      udf_q <= udf_set | (udf_q & ~err_clr);
    end
  end

  assign wr_vld       = wr_vld_q;
  assign rd_vld       = head_vld;
  assign rd_data      = buf0.data;
  assign rd_sof       = buf0.sb.sof;
  assign rd_eol       = buf0.sb.eol;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

endmodule

// File: tb/tb_video_prefetch_fifo.sv
// Randomised bench for video_prefetch_fifo (16-deep build) against a queue
// model of the pixel stream; a monitor checks every consumed pixel.
module tb_video_prefetch_fifo;

  localparam int DATA_W  = 24;
  localparam int DEPTH_W = 4;
  localparam int CAP     = 16;
  localparam int AF_THR  = 12;
  localparam int AE_THR  = 4;
  localparam int W       = DATA_W + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, flush = 1'b0, err_clr = 1'b0;
  logic              wr_en = 1'b0, wr_sof = 1'b0, wr_eol = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_vld, rd_vld, rd_sof, rd_eol, almost_full, almost_empty, ovf, udf;
  logic [DATA_W-1:0] rd_data;
  logic [DEPTH_W:0]  level;

  video_prefetch_fifo #(
    .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .AFULL_THR(AF_THR), .AEMPTY_THR(AE_THR)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
    .wr_en(wr_en), .wr_vld(wr_vld), .wr_data(wr_data), .wr_sof(wr_sof), .wr_eol(wr_eol),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .rd_sof(rd_sof), .rd_eol(rd_eol),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .ovf(ovf), .udf(udf)
  );

  int checks = 0;
  int failures = 0;

  // reference model: stream contents, acceptance edges, level and flags
  logic [W-1:0] exp_q[$];
  int           acc_t[$];
  int           cyc = 0;
  int           m_level = 0;
  bit           m_wv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // A pixel is presented two edges after it was accepted; one per cycle thereafter.
  function automatic bit head_visible();
    return (acc_t.size() > 0) && (cyc >= acc_t[0] + 2);
  endfunction

  task automatic check_all();
    chk("level", 32'(level), 32'(m_level));
    chk("wr_vld", 32'(wr_vld), 32'(m_wv));
    chk("rd_vld", 32'(rd_vld), 32'(head_visible()));
    chk("almost_full", 32'(almost_full), 32'(m_level >= AF_THR));
    chk("almost_empty", 32'(almost_empty), 32'(m_level <= AE_THR));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
  endtask

  // driver: one clock cycle of stimulus, model update, then a full check
  task automatic cycle(input bit w, input bit r, input bit f, input bit ec, input bit rs,
                       input logic [DATA_W-1:0] d, input bit s, input bit e);
    bit vis, acc, con;
    wr_en = w; rd_en = r; flush = f; err_clr = ec; rst = rs;
    wr_data = d; wr_sof = s; wr_eol = e;
    if (rs) begin
      m_level = 0; m_wv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      acc_t.delete(); exp_q.delete();
    end else if (f) begin
      m_level = 0; m_wv = 1'b1;
      m_ovf = m_ovf & ~ec; m_udf = m_udf & ~ec;
      acc_t.delete(); exp_q.delete();
    end else begin
      vis = head_visible();
      acc = w && m_wv;
      con = r && vis;
      m_ovf = (w && !m_wv) || (m_ovf && !ec);
      m_udf = (r && !vis) || (m_udf && !ec);
      if (con) void'(acc_t.pop_front());
      if (acc) begin
        acc_t.push_back(cyc + 1);
        exp_q.push_back({s, e, d});
      end
      m_level = m_level + int'(acc) - int'(con);
      m_wv = (m_level < CAP);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
    check_all();
  endtask

  task automatic idle(); cycle(0, 0, 0, 0, 0, '0, 0, 0); endtask
  task automatic wr_rand(); cycle(1, 0, 0, 0, 0, DATA_W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1); endtask
  task automatic rd_one(); cycle(0, 1, 0, 0, 0, '0, 0, 0); endtask
  task automatic clr_err(); cycle(0, 0, 0, 1, 0, '0, 0, 0); endtask

  task automatic drain();
    int guard = 0;
    while (m_level > 0 && guard < 200) begin
      cycle(0, head_visible(), 0, 0, 0, '0, 0, 0);
      guard++;
    end
  endtask

  // Brings the FIFO to level 10 with ovf set.
  task automatic fill_ten_with_ovf();
    repeat (CAP + 1) wr_rand();
    repeat (6) rd_one();
  endtask

  // scoreboard monitor: every consumed pixel must be the oldest expected one
  always @(posedge clk) begin
    if (!rst && !flush && rd_en && rd_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_empty at edge %0d: actual=%0h required=none", cyc, {rd_sof, rd_eol, rd_data});
      end else begin
        logic [W-1:0] exp_w;
        exp_w = exp_q.pop_front();
        if ({rd_sof, rd_eol, rd_data} !== exp_w) begin
          failures++;
          $display("FAIL pixel at edge %0d: actual=%0h required=%0h", cyc, {rd_sof, rd_eol, rd_data}, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset and reset values
    @(posedge clk);
    @(negedge clk);
    cycle(0, 0, 0, 0, 1, '0, 0, 0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_rd_sb", 32'({rd_sof, rd_eol}), 32'h0);
    idle();

    // basic ordering with frame tags
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0, DATA_W'(i + 1), i == 0, i == 15);
    repeat (16) rd_one();
    idle();

    // fill to full, 17th write dropped
    repeat (CAP + 1) wr_rand();
    clr_err();
    drain();

    // half full, read and write together every cycle
    repeat (CAP / 2) wr_rand();
    idle(); idle();
    repeat (100) cycle(1, 1, 0, 0, 0, DATA_W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    drain();

    // underflow, clear alone, clear colliding with a new underflow
    rd_one();
    clr_err();
    cycle(0, 1, 0, 1, 0, '0, 0, 0);
    clr_err();

    // flush mid-stream with a transfer in the same cycle
    fill_ten_with_ovf();
    cycle(1, 1, 1, 0, 0, DATA_W'($urandom), 0, 0);
    wr_rand();
    repeat (3) idle();
    drain();

    // reset mid-stream
    fill_ten_with_ovf();
    cycle(1, 1, 0, 0, 1, DATA_W'($urandom), 0, 0);
    chk("rst_mid_rd_data", 32'(rd_data), 32'h0);
    idle();
    idle();

    // randomised traffic
    repeat (400) begin
      bit f, ec;
      f  = $urandom_range(0, 99) < 2;
      ec = !f && ($urandom_range(0, 99) < 5);
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55, f, ec, 1'b0,
            DATA_W'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
